// File: rtl/audio_fifo_sequencer.sv
// ----------------------------------------------------------------------------
// audio_fifo_sequencer
//
// Sits between the SD byte stream (song_selection) and the frame assembler and
// owns the byte FIFO that links them.
//   * Write side: forwards SD bytes into the FIFO whenever it has room. A byte
//     that arrives while the FIFO is full is dropped and flagged.
//   * Refill control: sd_req asks for more SD data. It rises when the tracked
//     occupancy falls below LOW_WM and falls again at HIGH_WM. Between the two
//     marks it holds, so requests come in large blocks instead of chattering.
//   * Read side: pops bytes one at a time and packs SAMPLE_BYTES of them
//     little-endian. The first byte read lands in sample_out[7:0]. The packed
//     sample is offered downstream on a valid/ready handshake.
//   * Sticky status: overflow (byte dropped) and underrun (downstream wanted a
//     sample while the FIFO was empty). flag_clr clears both.
//
// Ports
//   clk_25mhz    in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   play enable; low pauses refill requests and FIFO reads
//   flag_clr     in   one-cycle pulse, clears overflow/underrun
//   byte_in      in   SD data byte
//   byte_valid   in   byte_in valid this cycle
//   sd_req       out  request for more SD data (level-sensitive)
//   fifo_full    in   FIFO full
//   fifo_empty   in   FIFO empty
//   fifo_wr_en   out  FIFO write strobe
//   fifo_din     out  FIFO write data
//   fifo_rd_en   out  FIFO read strobe; fifo_dout is valid one cycle later
//   fifo_dout    in   FIFO read data
//   sample_out   out  packed sample, first-read byte in [7:0]
//   sample_valid out  sample_out valid
//   sample_ready in   downstream accepts sample_out
//   level        out  tracked FIFO occupancy in bytes
//   overflow     out  sticky: byte dropped because the FIFO was full
//   underrun     out  sticky: downstream starved while enabled
// ----------------------------------------------------------------------------
module audio_fifo_sequencer #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned LOW_WM       = 256,
    parameter int unsigned HIGH_WM      = 768,
    parameter int unsigned SAMPLE_BYTES = 2,
    parameter int unsigned LVL_W        = 11
) (
    input  logic                      clk_25mhz,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      flag_clr,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    output logic                      sd_req,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    output logic                      fifo_wr_en,
    output logic [7:0]                fifo_din,
    output logic                      fifo_rd_en,
    input  logic [7:0]                fifo_dout,
    output logic [8*SAMPLE_BYTES-1:0] sample_out,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic [LVL_W-1:0]          level,
    output logic                      overflow,
    output logic                      underrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StFetch   = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StPresent = 2'd3;

    localparam logic [LVL_W-1:0] LowWm    = LVL_W'(LOW_WM);
    localparam logic [LVL_W-1:0] HighWm   = LVL_W'(HIGH_WM);
    localparam logic [LVL_W-1:0] DepthLvl = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LvlOne   = LVL_W'(1);
    localparam logic [1:0]       LastIdx  = 2'(SAMPLE_BYTES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]                state_q, state_d;
    logic [1:0]                idx_q, idx_d;
    logic [8*SAMPLE_BYTES-1:0] sample_q, sample_d;
    logic                      valid_q, valid_d;
    logic [LVL_W-1:0]          level_q, level_d;
    logic                      sd_req_q, sd_req_d;
    logic                      overflow_q, overflow_d;
    logic                      underrun_q, underrun_d;

    logic wr_fire;
    logic rd_fire;
    logic drop_evt;
    logic starve_evt;

    // ------------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------------
    // Writes ignore enable so an SD block already in flight still lands. The
    // strobe is also held low during reset: the level counter is held at zero
    // then, and a byte the counter never saw would leave it out of step with
    // the FIFO.
    assign wr_fire    = byte_valid & ~fifo_full & ~rst;
    assign fifo_wr_en = wr_fire;
    assign fifo_din   = byte_in;
    assign drop_evt   = byte_valid & fifo_full;

    // ------------------------------------------------------------------------
    // Read strobe
    // ------------------------------------------------------------------------
    // FETCH is left on the same edge that issues the read. No new read can
    // start until CAPTURE has taken the byte, so at most one read is ever
    // outstanding. The fifo_empty term keeps the strobe off an empty FIFO.
    assign rd_fire    = (state_q == StFetch) & enable & ~fifo_empty;
    assign fifo_rd_en = rd_fire;

    // ------------------------------------------------------------------------
    // Occupancy tracking
    // ------------------------------------------------------------------------
    // The saturation guards only matter if the attached FIFO disagrees with
    // DEPTH. In that case the counter pins at its limit rather than wrapping.
    always_comb begin
        level_d = level_q;
        unique case ({wr_fire, rd_fire})
            2'b10: begin
                if (level_q != DepthLvl) begin
                    level_d = level_q + LvlOne;
                end
            end
            2'b01: begin
                if (level_q != '0) begin
                    level_d = level_q - LvlOne;
                end
            end
            default: level_d = level_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Refill request with watermark hysteresis
    // ------------------------------------------------------------------------
    always_comb begin
        sd_req_d = sd_req_q;
        if (!enable || (level_q >= HighWm)) begin
            sd_req_d = 1'b0;
        end else if (level_q < LowWm) begin
            sd_req_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky flags: a set event in the same cycle as flag_clr wins
    // ------------------------------------------------------------------------
    assign starve_evt = enable & sample_ready & ~valid_q & fifo_empty;

    always_comb begin
        overflow_d = overflow_q;
        if (drop_evt) begin
            overflow_d = 1'b1;
        end else if (flag_clr) begin
            overflow_d = 1'b0;
        end

        underrun_d = underrun_q;
        if (starve_evt) begin
            underrun_d = 1'b1;
        end else if (flag_clr) begin
            underrun_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Read FSM and sample packer
    // ------------------------------------------------------------------------
    // Each byte costs two cycles: FETCH issues the read, and CAPTURE stores
    // the byte on the following cycle, when fifo_dout is valid. If enable
    // drops, the FSM parks in IDLE and keeps the partial sample and byte index
    // so packing resumes where it left off. PRESENT ignores enable: a sample
    // already offered is never withdrawn.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        valid_d  = valid_q;

        unique case (state_q)
            StIdle: begin
                if (enable && !valid_q) begin
                    state_d = StFetch;
                end
            end

            StFetch: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (!fifo_empty) begin
                    state_d = StCapture;
                end
            end

            StCapture: begin
                for (int b = 0; b < int'(SAMPLE_BYTES); b++) begin
                    if (idx_q == 2'(b)) begin
                        sample_d[8*b +: 8] = fifo_dout;
                    end
                end
                if (idx_q == LastIdx) begin
                    idx_d   = 2'd0;
                    valid_d = 1'b1;
                    state_d = StPresent;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StFetch;
                end
            end

            StPresent: begin
                if (valid_q && sample_ready) begin
                    valid_d = 1'b0;
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            level_q    <= '0;
            sd_req_q   <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            level_q    <= level_d;
            sd_req_q   <= sd_req_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sd_req       = sd_req_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_fifo_sequencer.sv
// Bench for audio_fifo_sequencer. It contains a behavioural byte FIFO that
// stands in for fifo_generator, plus a reference model built from the
// interface rules: occupancy equals the FIFO's byte count, watermark
// hysteresis on sd_req, sticky flags, and an in-order byte scoreboard packed
// little-endian.
module tb_audio_fifo_sequencer;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LOW_WM  = 256;
    localparam int unsigned HIGH_WM = 768;
    localparam int unsigned SB      = 2;
    localparam int unsigned LVL_W   = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              flag_clr = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              sd_req;
    logic              fifo_full = 1'b0;
    logic              fifo_empty = 1'b1;
    logic              fifo_wr_en;
    logic [7:0]        fifo_din;
    logic              fifo_rd_en;
    logic [7:0]        fifo_dout = 8'h00;
    logic [8*SB-1:0]   sample_out;
    logic              sample_valid;
    logic              sample_ready = 1'b0;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              underrun;

    int total = 0;
    int bad   = 0;

    audio_fifo_sequencer #(
        .DEPTH       (DEPTH),
        .LOW_WM      (LOW_WM),
        .HIGH_WM     (HIGH_WM),
        .SAMPLE_BYTES(SB),
        .LVL_W       (LVL_W)
    ) dut (
        .clk_25mhz   (clk),
        .rst         (rst),
        .enable      (enable),
        .flag_clr    (flag_clr),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .sd_req      (sd_req),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_dout   (fifo_dout),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .level       (level),
        .overflow    (overflow),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Behavioural first-word-fall-through-free byte FIFO (data one cycle after rd_en).
    logic [7:0] fq[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fifo_dout  <= 8'h00;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && fq.size() != 0) fifo_dout <= fq.pop_front();
            if (fifo_wr_en && fq.size() < DEPTH) fq.push_back(fifo_din);
            fifo_full  <= (fq.size() == DEPTH);
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && !sample_valid; i++) step();
        check(name, 32'(sample_valid), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sd_req"}, 32'(sd_req), 32'd0);
        check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        check({tag, "_sample_out"}, 32'(sample_out), 32'd0);
        check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Cycle monitor / reference model (evaluated mid-cycle on the falling edge)
    // ------------------------------------------------------------------------
    bit         mon_on = 1'b1;
    bit         p_rst = 1'b1, p_en, p_bv, p_full, p_empty, p_clr, p_rdy, p_valid;
    int         p_lvl;
    logic [15:0] p_out;
    bit         e_sd, e_ovf, e_unr;
    logic [7:0] exp_bytes[$];

    always @(negedge clk) begin
        if (mon_on) begin
            if (p_rst) begin
                e_sd = 1'b0; e_ovf = 1'b0; e_unr = 1'b0;
            end else begin
                if (!p_en || p_lvl >= int'(HIGH_WM)) e_sd = 1'b0;
                else if (p_lvl < int'(LOW_WM)) e_sd = 1'b1;
                if (p_bv && p_full) e_ovf = 1'b1;
                else if (p_clr) e_ovf = 1'b0;
                if (p_en && p_rdy && !p_valid && p_empty) e_unr = 1'b1;
                else if (p_clr) e_unr = 1'b0;
            end
            if (!rst) begin
                check("mon_sd_req", 32'(sd_req), 32'(e_sd));
                check("mon_overflow", 32'(overflow), 32'(e_ovf));
                check("mon_underrun", 32'(underrun), 32'(e_unr));
                check("mon_level", 32'(level), 32'(fq.size()));
                check("mon_wr_en", 32'(fifo_wr_en), 32'(byte_valid & ~fifo_full));
                check("mon_rd_on_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
                if (!p_rst && p_valid && !p_rdy) begin
                    check("mon_valid_hold", 32'(sample_valid), 32'd1);
                    check("mon_out_hold", 32'(sample_out), 32'(p_out));
                end
                if (byte_valid && !fifo_full) exp_bytes.push_back(byte_in);
                if (sample_valid && sample_ready) begin
                    if (exp_bytes.size() < SB) begin
                        check("sb_underflow", 32'(exp_bytes.size()), 32'(SB));
                    end else begin
                        logic [7:0] b0, b1;
                        b0 = exp_bytes.pop_front();
                        b1 = exp_bytes.pop_front();
                        check("sb_sample", 32'(sample_out), 32'({b1, b0}));
                    end
                end
            end else begin
                exp_bytes.delete();
            end
            p_rst = rst; p_en = enable; p_bv = byte_valid; p_full = fifo_full;
            p_empty = fifo_empty; p_clr = flag_clr; p_rdy = sample_ready;
            p_valid = sample_valid; p_lvl = fq.size(); p_out = sample_out;
        end
    end

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_s;
    } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h34, 8'h12, 16'h1234};
        vecs[1] = '{8'h00, 8'hff, 16'hff00};
        vecs[2] = '{8'hff, 8'h00, 16'h00ff};
        vecs[3] = '{8'ha5, 8'h5a, 16'h5aa5};
        vecs[4] = '{8'h80, 8'h01, 16'h0180};

        // Reset and first refill request
        repeat (3) step();
        check_all_zero("in_reset");
        rst = 1'b0;
        step();
        check_all_zero("post_reset");
        enable = 1'b1;
        step();
        check("sd_req_rise", 32'(sd_req), 32'd1);
        check("no_rd_empty", 32'(fifo_rd_en), 32'd0);

        // Table-driven two-byte samples with ready held high
        sample_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            send(vecs[v].b0);
            send(vecs[v].b1);
            wait_valid("tbl_valid");
            check("tbl_sample", 32'(sample_out), 32'(vecs[v].exp_s));
            step();
            check("tbl_valid_one_cycle", 32'(sample_valid), 32'd0);
        end

        // Backpressure: sample and FIFO frozen while ready is low
        sample_ready = 1'b0;
        send(8'hc1); send(8'hc2); send(8'hc3); send(8'hc4);
        wait_valid("bp_valid");
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_sample", 32'(sample_out), 32'h0000c2c1);
            check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
            check("bp_level", 32'(level), 32'd2);
        end
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        wait_valid("bp_valid2");
        check("bp_sample2", 32'(sample_out), 32'h0000c4c3);
        check("bp_level2", 32'(level), 32'd0);

        // Watermark hysteresis
        for (int i = 0; i < 767; i++) send(8'($urandom));
        check("lvl_767", 32'(level), 32'd767);
        check("sd_at_767", 32'(sd_req), 32'd1);
        send(8'($urandom));
        check("lvl_768", 32'(level), 32'd768);
        check("sd_edge_768", 32'(sd_req), 32'd1);
        step();
        check("sd_fall", 32'(sd_req), 32'd0);
        sample_ready = 1'b1;
        for (int i = 0; i < 3000 && level != 11'd255; i++) step();
        check("drain_to_255", 32'(level), 32'd255);
        check("sd_hold_256", 32'(sd_req), 32'd0);
        step();
        check("sd_rerise", 32'(sd_req), 32'd1);
        sample_ready = 1'b0;

        // Overflow
        for (int i = 0; i < 1100 && !fifo_full; i++) send(8'($urandom));
        check("level_full", 32'(level), 32'(DEPTH));
        byte_in = 8'hee;
        byte_valid = 1'b1;
        #1;
        check("wr_blocked", 32'(fifo_wr_en), 32'd0);
        step();
        byte_valid = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'(DEPTH));
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        byte_valid = 1'b1;
        flag_clr = 1'b1;
        step();
        byte_valid = 1'b0;
        flag_clr = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);

        // Underrun on an empty FIFO
        sample_ready = 1'b1;
        for (int i = 0; i < 3000 && level != 0; i++) step();
        check("drain_to_0", 32'(level), 32'd0);
        sample_ready = 1'b0;
        repeat (6) step();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("flags_clr", 32'({overflow, underrun}), 32'd0);
        sample_ready = 1'b1;
        step();
        step();
        check("unr_set", 32'(underrun), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("unr_no_rd", 32'(fifo_rd_en), 32'd0);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            enable       = (($urandom % 8) != 0);
            sample_ready = $urandom % 2;
            flag_clr     = (($urandom % 32) == 0);
            byte_in      = 8'($urandom);
            byte_valid   = ((i / 500) % 2 == 1) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            step();
        end
        byte_valid = 1'b0;
        flag_clr   = 1'b0;
        enable     = 1'b1;

        // Asynchronous reset mid-sample
        sample_ready = 1'b1;
        for (int i = 0; i < 3000 && (level != 0 || sample_valid); i++) step();
        sample_ready = 1'b0;
        send(8'h77);
        repeat (3) step();
        check("pre_rst_sd", 32'(sd_req), 32'd1);
        @(posedge clk);
        #3;
        mon_on = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_bytes.delete();
        step();
        p_rst = 1'b1;
        mon_on = 1'b1;
        step();
        rst = 1'b0;
        step();
        sample_ready = 1'b1;
        send(8'haa);
        send(8'hbb);
        wait_valid("post_rst_valid");
        check("post_rst_sample", 32'(sample_out), 32'h0000bbaa);
        step();
        sample_ready = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
